// File: rtl/compa_seq_wide_if.sv
// ---------------------------------------------------------------------------
// compa_seq_wide_if
//   Request/result bundle for the byte-serial wide magnitude comparator.
//   master : requester side (drives start, operands and cascade seed)
//   slave  : comparator side (drives busy, done and the registered result)
//
//   start   request, honoured only while busy is low
//   a, b    operands, 8*NBYTES bits, captured on an accepted start
//   agtbin  cascade seed "greater"
//   altbin  cascade seed "less"
//   aeqbin  cascade seed "equal"
//   busy    comparator is walking bytes or presenting done
//   done    one-cycle completion pulse
//   agtb    result A > B
//   altb    result A < B
//   aeqb    result A == B (or the seed when every byte matched)
// ---------------------------------------------------------------------------
interface compa_seq_wide_if #(
    parameter int NBYTES = 4
) ();
    logic                  start;
    logic [8*NBYTES-1:0]   a;
    logic [8*NBYTES-1:0]   b;
    logic                  agtbin;
    logic                  altbin;
    logic                  aeqbin;
    logic                  busy;
    logic                  done;
    logic                  agtb;
    logic                  altb;
    logic                  aeqb;

    modport master (
        output start, a, b, agtbin, altbin, aeqbin,
        input  busy, done, agtb, altb, aeqb
    );

    modport slave (
        input  start, a, b, agtbin, altbin, aeqbin,
        output busy, done, agtb, altb, aeqb
    );
endinterface

// File: rtl/compa_seq_wide.sv
// ---------------------------------------------------------------------------
// compa_seq_wide
//   Multi-cycle unsigned magnitude comparator for 8*NBYTES-bit operands.
//   The operands are walked one byte per clock, least significant byte first,
//   while a registered gt/lt/eq cascade is carried between bytes. A differing
//   byte overwrites the cascade, so the most significant differing byte has
//   the final say; equal bytes leave it untouched, so an all-equal operand
//   pair reports the seed. The result can seed a downstream 8-bit stage.
//
// Ports
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   bus     compa_seq_wide_if.slave:
//             start/a/b/agtbin/altbin/aeqbin in, busy/done/agtb/altb/aeqb out
//
// Timing
//   Start edge E0 -> RUN edges 1..NBYTES (one byte each) -> DONE for one
//   cycle (done=1, result visible) -> IDLE. Results only change on entry
//   to DONE and hold until the next completion or reset.
// ---------------------------------------------------------------------------
module compa_seq_wide #(
    parameter int NBYTES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    compa_seq_wide_if.slave      bus
);

    localparam int W     = 8 * NBYTES;
    // One extra code point so the index can step past the last byte without
    // wrapping back to zero inside an operation.
    localparam int IDX_W = $clog2(NBYTES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    // Cascade encoding {gt, lt, eq}
    localparam logic [2:0] CASC_GT   = 3'b100;
    localparam logic [2:0] CASC_LT   = 3'b010;
    localparam logic [2:0] CASC_EQ   = 3'b001;
    localparam logic [2:0] CASC_NONE = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_reg;
    logic [W-1:0]      a_reg;
    logic [W-1:0]      b_reg;
    logic [2:0]        casc_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              agtb_reg;
    logic              altb_reg;
    logic              aeqb_reg;

    // -----------------------------------------------------------------------
    // Per-byte compare of the captured operands, then a one-hot select of
    // the byte currently addressed by idx_reg.
    // -----------------------------------------------------------------------
    logic [NBYTES-1:0] byte_gt;
    logic [NBYTES-1:0] byte_lt;
    logic [NBYTES-1:0] byte_sel;

    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_byte
        assign byte_gt[gi]  = (a_reg[8*gi +: 8] > b_reg[8*gi +: 8]);
        assign byte_lt[gi]  = (a_reg[8*gi +: 8] < b_reg[8*gi +: 8]);
        assign byte_sel[gi] = (idx_reg == IDX_W'(gi));
    end

    logic sel_gt;
    logic sel_lt;

    assign sel_gt = |(byte_gt & byte_sel);
    assign sel_lt = |(byte_lt & byte_sel);

    // Cascade after applying the current byte.
    logic [2:0] casc_next;

    always_comb begin
        casc_next = casc_reg;
        if (sel_gt) begin
            casc_next = CASC_GT;
        end else if (sel_lt) begin
            casc_next = CASC_LT;
        end
    end

    // Only a one-hot seed is meaningful; anything else starts the cascade
    // with no flag set so an all-equal compare reports nothing.
    logic [2:0] seed_casc;

    always_comb begin
        seed_casc = CASC_NONE;
        case ({bus.agtbin, bus.altbin, bus.aeqbin})
            CASC_GT: seed_casc = CASC_GT;
            CASC_LT: seed_casc = CASC_LT;
            CASC_EQ: seed_casc = CASC_EQ;
            default: seed_casc = CASC_NONE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Control FSM with registered outputs.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            casc_reg  <= CASC_NONE;
            idx_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            agtb_reg  <= 1'b0;
            altb_reg  <= 1'b0;
            aeqb_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    done_reg <= 1'b0;
                    if (bus.start) begin
                        a_reg     <= bus.a;
                        b_reg     <= bus.b;
                        casc_reg  <= seed_casc;
                        idx_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    casc_reg <= casc_next;
                    idx_reg  <= idx_reg + 1'b1;
                    if (idx_reg == LAST_IDX) begin
                        // Last byte: publish the cascade including this byte.
                        {agtb_reg, altb_reg, aeqb_reg} <= casc_next;
                        done_reg  <= 1'b1;
                        state_reg <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    // start is ignored here; it is not remembered for later.
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end

                default: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.agtb = agtb_reg;
    assign bus.altb = altb_reg;
    assign bus.aeqb = aeqb_reg;

endmodule
